// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants and helpers for the element-stream stages
//            (element fifo, packer and output register stage).
// Contents : default element width, default pack ratio / pointer widths,
//            ratio helper and keep-mask width constant.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default width of one stream element.
    localparam int c_ELE_BANDWIDTH_DEFAULT   = 8;

    // Default log2 of elements packed per output word.
    localparam int c_PACK_RATIO_LOG2_DEFAULT = 2;

    // Default pointer width of the upstream element fifo.
    localparam int c_PTR_WIDTH_DEFAULT       = 4;

    // Elements per output word for a given log2 ratio.
    function automatic int ratio_of(input int pack_ratio_log2);
        return 1 << pack_ratio_log2;
    endfunction

    // Keep mask carries one bit per lane of the packed word.
    localparam int c_KEEP_WIDTH_DEFAULT = ratio_of(c_PACK_RATIO_LOG2_DEFAULT);

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/pipe_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_out_reg
// Purpose  : Registered valid/ready output stage carrying data, keep and
//            last. A loaded word is held stable until the downstream
//            handshake completes; a new load may coincide with a drain so
//            the stage sustains one word per cycle.
// Ports    : i_clk, i_rst       - clock, synchronous active-high reset
//            i_load             - upstream presents a word to capture
//            i_data/i_keep/i_last - payload to capture
//            o_ready            - stage can capture a word this cycle
//            o_valid/o_data/o_keep/o_last - registered output word
//            i_ready            - downstream accepts the output word
// Revision : 1.0 - initial release
// ============================================================================
module pipe_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last,
    input  logic              i_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;

    // Space exists when the register is empty or is being drained this cycle.
    // Forced low in reset so nothing upstream is accepted into a clearing stage.
    assign o_ready = ~i_rst & (~r_valid | i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            // Upstream only loads while o_ready is high, so nothing is overwritten.
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (i_ready) begin
            // Payload is left stale; it is don't-care while valid is low.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule : pipe_out_reg
`default_nettype wire

// File: rtl/fifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_packer
// Purpose  : Width up-converter for the element stream. Packs RATIO
//            consecutive elements (lane 0 first) into one wide word; i_last
//            flushes a partial word with unused lanes zeroed and their keep
//            bits clear.
// Ports    : i_clk, i_rst            - clock, synchronous active-high reset
//            i_data/i_valid/i_last   - input element stream
//            o_ready                 - element accepted when i_valid & o_ready
//            o_valid/o_data/o_keep/o_last - registered packed word
//            i_ready                 - downstream accepts the packed word
// Revision : 1.0 - initial release
// ============================================================================
module fifo_packer
    import fifo_pkg::*;
#(
    parameter int ELE_BANDWIDTH   = c_ELE_BANDWIDTH_DEFAULT,
    parameter int PACK_RATIO_LOG2 = c_PACK_RATIO_LOG2_DEFAULT
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic [ELE_BANDWIDTH-1:0]                   i_data,
    input  logic                                       i_valid,
    input  logic                                       i_last,
    output logic                                       o_ready,
    output logic                                       o_valid,
    output logic [ELE_BANDWIDTH*ratio_of(PACK_RATIO_LOG2)-1:0] o_data,
    output logic [ratio_of(PACK_RATIO_LOG2)-1:0]       o_keep,
    output logic                                       o_last,
    input  logic                                       i_ready
);

    localparam int RATIO  = ratio_of(PACK_RATIO_LOG2);
    localparam int WORD_W = ELE_BANDWIDTH * RATIO;

    localparam logic [PACK_RATIO_LOG2-1:0] c_CNT_LAST = '1;
    localparam logic [PACK_RATIO_LOG2-1:0] c_CNT_ONE  = PACK_RATIO_LOG2'(1);

    logic [PACK_RATIO_LOG2-1:0] r_cnt;
    logic [WORD_W-1:0]          r_acc;
    logic [RATIO-1:0]           r_acc_keep;

    logic [WORD_W-1:0]          w_merged_data;
    logic [RATIO-1:0]           w_merged_keep;
    logic                       w_accept;
    logic                       w_complete;
    logic                       w_out_ready;

    assign o_ready    = w_out_ready;
    assign w_accept   = i_valid & w_out_ready;
    assign w_complete = w_accept & ((r_cnt == c_CNT_LAST) | i_last);

    // Accumulator with the incoming element dropped into lane r_cnt. Lanes
    // above r_cnt are still zero here, which gives zeroed tails on a flush.
    generate
        for (genvar k = 0; k < RATIO; k++) begin : g_lane
            logic w_sel;
            assign w_sel = (r_cnt == PACK_RATIO_LOG2'(k));
            assign w_merged_data[k*ELE_BANDWIDTH +: ELE_BANDWIDTH] =
                w_sel ? i_data : r_acc[k*ELE_BANDWIDTH +: ELE_BANDWIDTH];
            assign w_merged_keep[k] = r_acc_keep[k] | w_sel;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                // Word handed to the output stage; start the next at lane 0.
                r_cnt      <= '0;
                r_acc      <= '0;
                r_acc_keep <= '0;
            end else begin
                r_cnt      <= r_cnt + c_CNT_ONE;
                r_acc      <= w_merged_data;
                r_acc_keep <= w_merged_keep;
            end
        end
    end

    pipe_out_reg #(
        .DATA_W (WORD_W),
        .KEEP_W (RATIO)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_complete),
        .i_data  (w_merged_data),
        .i_keep  (w_merged_keep),
        .i_last  (i_last),
        .o_ready (w_out_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

endmodule : fifo_packer
`default_nettype wire

// File: doc/fifo_packer.md
Name: fifo_packer

Overview:
- Width up-converter on the valid/ready element stream; sits directly downstream of the element fifo.
- Accepts ELE_BANDWIDTH-bit elements one per cycle and packs RATIO consecutive elements into one wide word.
- Emits each word through a registered valid/ready output with per-lane keep mask and last flag.
- i_last flushes a partial word, so packet tails are never stranded in the accumulator.

Parameters:
- ELE_BANDWIDTH, 8, width of one input element.
- PACK_RATIO_LOG2, 2, log2 of elements per output word; RATIO = 1<<PACK_RATIO_LOG2 (default 4). Legal range 1..4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_data  in  ELE_BANDWIDTH  input element.
- i_valid  in  1  input element valid.
- i_last  in  1  element is the final one of a packet; qualified by i_valid.
- o_ready  out  1  packer accepts an element this cycle.
- o_valid  out  1  output word valid.
- o_data  out  ELE_BANDWIDTH*RATIO  packed word; lane k = bits [k*ELE_BANDWIDTH +: ELE_BANDWIDTH].
- o_keep  out  RATIO  lane k holds a real element.
- o_last  out  1  word closes a packet.
- i_ready  in  1  downstream accepts the word.

Behaviour:
- Reset: i_rst synchronous, active-high; clock i_clk.
  - While i_rst is high: o_valid=0, o_data=0, o_keep=0, o_last=0, lane counter=0, accumulator=0, o_ready=0.
  - First cycle after release: o_ready=1.
  - Reset mid-packet discards the partial accumulator and any held output word without emitting them.
- Handshake:
  - accept = i_valid & o_ready.
  - o_ready = ~i_rst & (~o_valid | i_ready), combinational.
  - o_valid must not depend combinationally on i_ready.
  - Once o_valid=1, o_data, o_keep and o_last hold stable until o_valid & i_ready.
- Packing:
  - Lane counter cnt, PACK_RATIO_LOG2 bits.
  - First element of a word goes to lane 0; ascending lane order.
  - On accept, element is written to lane cnt of the accumulator and acc_keep[cnt] is set.
- Completion: the accepted beat completes the word if cnt==RATIO-1 or i_last=1. On a completing accept, next cycle:
  - output register <= accumulator with the new element merged.
  - o_keep <= acc_keep | (1<<cnt); o_last <= i_last; o_valid <= 1.
  - cnt <= 0; accumulator and acc_keep cleared.
- Non-completing accept: cnt <= cnt+1 only.
- Unused lanes in a flushed word are 0; keep bits for those lanes are 0.
- Output drain: o_valid & i_ready with no completing accept clears o_valid next cycle. o_data/o_keep/o_last may hold stale values but are don't-care while o_valid=0.
- Simultaneous drain and completing accept: new word loads, o_valid stays 1. No bubble; sustained throughput is 1 element/cycle.
- Latency: completing beat at cycle N gives o_valid at N+1.
- Boundary cases:
  - i_last on lane 0 gives keep=...0001.
  - i_last on lane RATIO-1 gives a full word with o_last=1.
  - cnt wraps RATIO-1 -> 0.
  - Output stalled (o_valid & ~i_ready): o_ready=0, accumulator frozen, no element lost.
- States (implicit, from o_valid and cnt):
  - EMPTY (o_valid=0, cnt=0)
  - FILLING (cnt>0)
  - HOLD (o_valid=1, ~i_ready)
  - Transitions follow the rules above.

Decomposition:
- Shared package fifo_pkg holds:
  - default ELE_BANDWIDTH (8) and default pointer/ratio widths.
  - localparam helper for RATIO = 1<<PACK_RATIO_LOG2.
  - keep-mask width constant.
- One natural sub-module: pipe_out_reg. It is the registered valid/ready output stage (data+keep+last payload) with the load/hold/drain rules above; it is reusable by other stream stages.
- Accumulator and counter live in fifo_packer itself.

Test Plan:
- Reset then stream 0x11,0x22,0x33,0x44 with i_ready=1 -> o_data=0x44332211, o_keep=4'b1111, o_last=0, o_valid one cycle after the 0x44 accept.
- Stream 0xA1,0xA2 with i_last on 0xA2 -> o_data=0x0000A2A1, o_keep=4'b0011, o_last=1; next word starts at lane 0.
- Single element 0x5C with i_last -> o_data=0x0000005C, o_keep=4'b0001, o_last=1.
- Hold i_ready=0 with a word pending, drive 8 elements -> o_ready=0, o_data stable. Release i_ready -> both words emitted in order, none dropped or duplicated.
- Back-to-back 16 elements, i_ready=1 continuously -> o_ready never drops, 4 words on consecutive 4-cycle boundaries.
- Assert i_rst after 2 of 4 elements -> all outputs 0 during reset; next 4 elements produce one clean word with no residue from the discarded 2.
